// File: rtl/vga_frame_writer.sv
// vga_frame_writer
// Avalon-MM write master that copies an 8-bit pixel stream into one SDRAM
// frame buffer, pixel n landing at byte address base+n. The buffer layout is
// the same one the VGA read path scans out.
module vga_frame_writer #(
    parameter int FRAME_PIXELS = 307200,
    parameter int IDX_W        = 20,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       frame_base_addr,
    input  logic              frame_go,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic [31:0]       master_address,
    output logic              master_write,
    output logic              master_byteenable,
    output logic [DATA_W-1:0] master_writedata,
    input  logic              master_waitrequest,
    output logic              frame_busy,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              sof_err
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WRITE,
        DONE
    } state_t;

    // idx runs 0..FRAME_PIXELS; the terminal value means "last pixel issued".
    localparam logic [IDX_W-1:0] FRAME_END = IDX_W'(FRAME_PIXELS);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       base_q;

    logic              accept;     // slave takes the current request this cycle
    logic              slot;       // output register is free for a new request
    logic              transfer;   // stream handshake completes this cycle
    logic              load_pix;   // transfer that becomes a bus write
    logic              restart;    // sof arriving in the middle of a frame

    assign accept   = master_write & ~master_waitrequest;
    assign slot     = ~master_write | ~master_waitrequest;
    assign transfer = pix_valid & pix_ready;
    // In ARM only the sof pixel is written; earlier pixels are swallowed.
    assign load_pix = transfer & ((state == WRITE) | ((state == ARM) & pix_sof));
    assign restart  = transfer & pix_sof & (state == WRITE);

    assign master_byteenable = 1'b1;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples the pre-edge values regardless of statement order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and combinational stream/status outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt  = state;
        pix_ready  = 1'b0;
        frame_done = 1'b0;
        frame_busy = 1'b1;
        case (state)
            IDLE: begin
                frame_busy = 1'b0;
                if (frame_go) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                pix_ready = 1'b1;
                if (pix_valid && pix_sof) begin
                    state_nxt = WRITE;
                end else if (!frame_go) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                pix_ready = slot & (idx < FRAME_END);
                if (accept && (idx == FRAME_END)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = frame_go ? ARM : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Avalon request register: loads on a stream transfer, clears once accepted.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: reset is asynchronous, so a request held by waitrequest is
        // dropped on the spot rather than at the next edge.
        if (reset) begin
            master_write     <= 1'b0;
            master_address   <= 32'd0;
            master_writedata <= '0;
        end else if (load_pix) begin
            // A new request may replace one being accepted this same cycle,
            // which keeps master_write high at one pixel per clock.
            master_write     <= 1'b1;
            master_writedata <= pix_data;
            master_address   <= pix_sof ? frame_base_addr : (base_q + 32'(idx));
        end else if (accept) begin
            master_write     <= 1'b0;
        end
    end

    // Frame base and pixel index tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q <= 32'd0;
            idx    <= '0;
        end else if (load_pix) begin
            if (pix_sof) begin
                base_q <= frame_base_addr;
                idx    <= IDX_ONE;
            end else begin
                idx    <= idx + IDX_ONE;
            end
        end else if (state == DONE) begin
            idx <= '0;
        end
    end

    // Completed-frame counter and sticky restart error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= 16'd0;
            sof_err     <= 1'b0;
        end else begin
            if (state == DONE) begin
                frame_count <= frame_count + 16'd1;
            end
            if (restart) begin
                sof_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_writer.sv
// tb_vga_frame_writer
// Directed stimulus with a write scoreboard: the stimulus side queues the
// expected (address, data) of every pixel that should reach the bus, and a
// monitor pops and compares on every accepted Avalon write.
module tb_vga_frame_writer;

    localparam int FP = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] frame_base_addr;
    logic        frame_go;
    logic        pix_valid;
    logic        pix_sof;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic [31:0] master_address;
    logic        master_write;
    logic        master_byteenable;
    logic [7:0]  master_writedata;
    logic        master_waitrequest;
    logic        frame_busy;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        sof_err;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t  sb_q[$];
    int   acc_cyc[$];
    int   errors     = 0;
    int   checks     = 0;
    int   cyc        = 0;
    int   done_seen  = 0;
    int   last_acc   = -10;
    int   stall_seen = 0;

    vga_frame_writer #(
        .FRAME_PIXELS(FP),
        .IDX_W       (4),
        .DATA_W      (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .frame_base_addr   (frame_base_addr),
        .frame_go          (frame_go),
        .pix_valid         (pix_valid),
        .pix_sof           (pix_sof),
        .pix_data          (pix_data),
        .pix_ready         (pix_ready),
        .master_address    (master_address),
        .master_write      (master_write),
        .master_byteenable (master_byteenable),
        .master_writedata  (master_writedata),
        .master_waitrequest(master_waitrequest),
        .frame_busy        (frame_busy),
        .frame_done        (frame_done),
        .frame_count       (frame_count),
        .sof_err           (sof_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        sb_q.push_back(w);
    endtask

    // Present one pixel and hold it until the DUT takes it.
    task automatic push_pix(input logic [7:0] d, input logic sof);
        logic rdy;
        int   k;
        rdy = 1'b0;
        k   = 0;
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_data  = d;
        while (!rdy && k < 100) begin
            @(negedge clk);
            rdy = pix_ready;
            @(posedge clk);
            #1;
            k++;
        end
        check("pix_accepted", {31'd0, rdy}, 32'd1);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (done_seen < n && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("done_count", done_seen, n);
    endtask

    // Stall the slave for 5 cycles once the request at address a appears.
    task automatic stall_at(input logic [31:0] a);
        logic found;
        int   k;
        found = 1'b0;
        k     = 0;
        while (!found && k < 200) begin
            @(posedge clk);
            #1;
            k++;
            if (master_write && master_address == a) found = 1'b1;
        end
        check("stall_target_seen", {31'd0, found}, 32'd1);
        if (found) begin
            master_waitrequest = 1'b1;
            repeat (5) @(posedge clk);
            #1;
            master_waitrequest = 1'b0;
        end
    endtask

    // Monitor: scoreboard compare on accept, hold rules during stalls,
    // frame_done timing relative to the last accept.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_addr;
        logic [7:0]  prev_data;
        wr_t         w;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_write", {31'd0, master_write}, 32'd1);
                    check("stall_hold_addr", master_address, prev_addr);
                    check("stall_hold_data", {24'd0, master_writedata}, {24'd0, prev_data});
                end
                if (master_write && master_waitrequest) begin
                    check("stall_pix_ready", {31'd0, pix_ready}, 32'd0);
                    stall_seen++;
                end
                prev_stall = master_write & master_waitrequest;
                prev_addr  = master_address;
                prev_data  = master_writedata;
                if (master_write && !master_waitrequest) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                                 master_address, master_writedata);
                    end else begin
                        w = sb_q.pop_front();
                        check("wr_addr", master_address, w.addr);
                        check("wr_data", {24'd0, master_writedata}, {24'd0, w.data});
                    end
                    acc_cyc.push_back(cyc);
                    last_acc = cyc;
                end
                if (frame_done) begin
                    done_seen++;
                    check("done_latency", cyc, last_acc + 1);
                end
            end
        end
    end

    initial begin
        reset              = 1'b1;
        frame_base_addr    = 32'd0;
        frame_go           = 1'b0;
        pix_valid          = 1'b0;
        pix_sof            = 1'b0;
        pix_data           = 8'd0;
        master_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_write", {31'd0, master_write}, 32'd0);
        check("rst_addr", master_address, 32'd0);
        check("rst_data", {24'd0, master_writedata}, 32'd0);
        check("rst_ready", {31'd0, pix_ready}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_count", {16'd0, frame_count}, 32'd0);
        check("rst_sof_err", {31'd0, sof_err}, 32'd0);
        check("rst_busy", {31'd0, frame_busy}, 32'd0);
        check("byteenable", {31'd0, master_byteenable}, 32'd1);
        reset = 1'b0;

        // Steady state: 8 back-to-back pixels at 0x1000
        frame_base_addr = 32'h0000_1000;
        frame_go        = 1'b1;
        acc_cyc.delete();
        for (int i = 0; i < FP; i++) begin
            expect_wr(32'h0000_1000 + i, 8'(8'h10 + i));
            push_pix(8'(8'h10 + i), i == 0);
        end
        wait_done(1);
        check("steady_count", {16'd0, frame_count}, 32'd1);
        check("steady_accepts", acc_cyc.size(), FP);
        if (acc_cyc.size() == FP) check("steady_span", acc_cyc[FP-1] - acc_cyc[0], FP - 1);
        check("steady_sb_empty", sb_q.size(), 0);
        check("steady_sof_err", {31'd0, sof_err}, 32'd0);

        // Slave stall of 5 cycles on idx 3
        frame_base_addr = 32'h0000_2000;
        stall_seen      = 0;
        fork
            stall_at(32'h0000_2003);
            begin
                for (int i = 0; i < FP; i++) begin
                    expect_wr(32'h0000_2000 + i, 8'(8'h20 + i));
                    push_pix(8'(8'h20 + i), i == 0);
                end
            end
        join
        wait_done(2);
        check("stall_count", {16'd0, frame_count}, 32'd2);
        check("stall_cycles", stall_seen, 5);
        check("stall_sb_empty", sb_q.size(), 0);

        // Pre-sof discard in ARM
        frame_base_addr = 32'h0000_3000;
        push_pix(8'h01, 1'b0);
        push_pix(8'h02, 1'b0);
        push_pix(8'h03, 1'b0);
        expect_wr(32'h0000_3000, 8'hAA);
        push_pix(8'hAA, 1'b1);
        for (int i = 1; i < FP; i++) begin
            expect_wr(32'h0000_3000 + i, 8'(8'hB0 + i));
            push_pix(8'(8'hB0 + i), 1'b0);
        end
        wait_done(3);
        check("discard_count", {16'd0, frame_count}, 32'd3);
        check("discard_sb_empty", sb_q.size(), 0);

        // Frame restart: sof at idx 5 with a new base
        frame_base_addr = 32'h0000_4000;
        for (int i = 0; i < 5; i++) begin
            expect_wr(32'h0000_4000 + i, 8'(8'h40 + i));
            push_pix(8'(8'h40 + i), i == 0);
        end
        frame_base_addr = 32'h0000_5000;
        expect_wr(32'h0000_5000, 8'h55);
        push_pix(8'h55, 1'b1);
        check("restart_sof_err", {31'd0, sof_err}, 32'd1);
        check("restart_count", {16'd0, frame_count}, 32'd3);
        for (int i = 1; i < FP; i++) begin
            expect_wr(32'h0000_5000 + i, 8'(8'h60 + i));
            push_pix(8'(8'h60 + i), 1'b0);
        end
        check("restart_no_done", done_seen, 3);
        wait_done(4);
        check("restart_count_end", {16'd0, frame_count}, 32'd4);
        check("restart_sb_empty", sb_q.size(), 0);

        // Enable drop at idx 2, base near the top of the address space
        frame_base_addr = 32'hFFFF_FFFE;
        expect_wr(32'hFFFF_FFFE, 8'h70);
        push_pix(8'h70, 1'b1);
        expect_wr(32'hFFFF_FFFF, 8'h71);
        push_pix(8'h71, 1'b0);
        frame_go = 1'b0;
        for (int i = 2; i < FP; i++) begin
            expect_wr(32'(i - 2), 8'(8'h70 + i));
            push_pix(8'(8'h70 + i), 1'b0);
        end
        wait_done(5);
        repeat (2) @(posedge clk);
        #1;
        check("drop_busy", {31'd0, frame_busy}, 32'd0);
        check("drop_ready", {31'd0, pix_ready}, 32'd0);
        check("drop_count", {16'd0, frame_count}, 32'd5);
        check("drop_sb_empty", sb_q.size(), 0);

        // Reset mid-WRITE while the slave stalls
        frame_go        = 1'b1;
        frame_base_addr = 32'h0000_6000;
        expect_wr(32'h0000_6000, 8'h80);
        push_pix(8'h80, 1'b1);
        expect_wr(32'h0000_6001, 8'h81);
        push_pix(8'h81, 1'b0);
        master_waitrequest = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_pending", {31'd0, master_write}, 32'd1);
        check("pre_rst_sb", sb_q.size(), 1);
        reset = 1'b1;
        #1;
        check("async_rst_write", {31'd0, master_write}, 32'd0);
        check("async_rst_ready", {31'd0, pix_ready}, 32'd0);
        check("async_rst_count", {16'd0, frame_count}, 32'd0);
        @(posedge clk);
        #1;
        check("edge_rst_write", {31'd0, master_write}, 32'd0);
        check("edge_rst_ready", {31'd0, pix_ready}, 32'd0);
        check("edge_rst_count", {16'd0, frame_count}, 32'd0);
        check("edge_rst_busy", {31'd0, frame_busy}, 32'd0);
        sb_q.delete();
        master_waitrequest = 1'b0;
        frame_go           = 1'b0;
        reset              = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
